// File: rtl/sbapd.sv
// sbapd: SPI-loaded register file driving an independent ALU and a two-step MAC.
//
// Ports
//   spi_en     active-low frame enable (asynchronous to clk)
//   spi_clk    serial bit clock (asynchronous, period >= 8 clk)
//   spi_wdata  24-bit master word, MSB sent first
//   aluop_st   ALU start level, rising edge triggers one operation
//   macop_st   MAC start level, rising edge triggers one operation
//   rst        asynchronous active-low reset
//   clk        system clock
//   alu_out    ALU result, alu_done pulses when it updates
//   mac_out    33-bit MAC result, mac_done pulses when it updates
//   mac_busy   high while a MAC operation is in progress
//
// MAC state | meaning
// ----------+----------------------------------------------
// MAC_IDLE  | waiting for a macop_st edge
// MAC_ACC   | acc holds R4*R5, adding R6*R7 this cycle
// MAC_OUT   | acc complete, publishing to mac_out
module sbapd #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        spi_en,
    input  logic        spi_clk,
    input  logic [23:0] spi_wdata,
    input  logic        aluop_st,
    input  logic        macop_st,
    input  logic        rst,
    input  logic        clk,
    output logic [15:0] alu_out,
    output logic        alu_done,
    output logic [32:0] mac_out,
    output logic        mac_busy,
    output logic        mac_done
);

    typedef enum logic [1:0] {MAC_IDLE, MAC_ACC, MAC_OUT} mac_state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, sen_sync, alu_sync, mac_sync;
    logic                   sclk_prev, sen_prev, alu_prev, mac_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            sen_sync  <= '0;
            alu_sync  <= '0;
            mac_sync  <= '0;
            sclk_prev <= 1'b0;
            sen_prev  <= 1'b0;
            alu_prev  <= 1'b0;
            mac_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            sen_sync  <= {sen_sync[SYNC_STAGES-2:0], spi_en};
            alu_sync  <= {alu_sync[SYNC_STAGES-2:0], aluop_st};
            mac_sync  <= {mac_sync[SYNC_STAGES-2:0], macop_st};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            sen_prev  <= sen_sync[SYNC_STAGES-1];
            alu_prev  <= alu_sync[SYNC_STAGES-1];
            mac_prev  <= mac_sync[SYNC_STAGES-1];
        end
    end

    logic sen_s, sclk_rise, sen_fall, sen_rise, alu_start, mac_start;
    assign sen_s     = sen_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sen_fall  = ~sen_s & sen_prev;
    assign sen_rise  = sen_s & ~sen_prev;
    assign alu_start = alu_sync[SYNC_STAGES-1] & ~alu_prev;
    assign mac_start = mac_sync[SYNC_STAGES-1] & ~mac_prev;

    // Only the low 22 bits of the frame are ever used, so the top two bits
    // simply fall off the end of the shift register.
    logic [21:0] shreg;
    logic [4:0]  bit_cnt;
    logic        frame_act;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [18:0] wr_data;
    logic [4:0]  bit_idx;

    assign wr_en   = frame_act && (bit_cnt == 5'd24);
    assign wr_addr = shreg[21:19];
    assign wr_data = shreg[18:0];
    assign bit_idx = 5'd23 - bit_cnt;

    // frame_act only sets on a seen falling edge of spi_en, so a frame that
    // was open across reset never resumes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_act <= 1'b0;
        end else if (sen_fall) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_act <= 1'b1;
        end else if (wr_en || sen_rise) begin
            frame_act <= 1'b0;
        end else if (frame_act && !sen_s && sclk_rise && bit_cnt < 5'd24) begin
            shreg   <= {shreg[20:0], spi_wdata[bit_idx]};
            bit_cnt <= bit_cnt + 5'd1;
        end
    end

    logic [18:0] regs [8];
    logic [18:0] fwd  [8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Operand view with the pending write folded in, so a start in the
    // write cycle sees the new value.
    always_comb begin
        for (int i = 0; i < 8; i++) fwd[i] = regs[i];
        if (wr_en) fwd[wr_addr] = wr_data;
    end

    logic        alu_pend;
    logic [2:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_res;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            3'b000:  alu_res = alu_a + alu_b;
            3'b001:  alu_res = alu_a - alu_b;
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b100:  alu_res = alu_a ^ alu_b;
            3'b101:  alu_res = ~alu_a;
            3'b110:  alu_res = alu_a << alu_b[3:0];
            default: alu_res = alu_a >> alu_b[3:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_pend <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_out  <= '0;
            alu_done <= 1'b0;
        end else begin
            alu_pend <= alu_start;
            alu_done <= alu_pend;
            if (alu_start) begin
                alu_op <= fwd[0][18:16];
                alu_a  <= fwd[1][15:0];
                alu_b  <= fwd[2][15:0];
            end
            if (alu_pend) alu_out <= alu_res;
        end
    end

    mac_state_t  mac_state;
    logic [32:0] acc;
    logic [15:0] mac_c, mac_d;
    logic [31:0] prod_ab, prod_cd;

    assign prod_ab = {16'b0, fwd[4][15:0]} * {16'b0, fwd[5][15:0]};
    assign prod_cd = {16'b0, mac_c} * {16'b0, mac_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_state <= MAC_IDLE;
            acc       <= '0;
            mac_c     <= '0;
            mac_d     <= '0;
            mac_out   <= '0;
            mac_busy  <= 1'b0;
            mac_done  <= 1'b0;
        end else begin
            mac_done <= 1'b0;
            case (mac_state)
                MAC_IDLE: begin
                    if (mac_start) begin
                        acc       <= {1'b0, prod_ab};
                        mac_c     <= fwd[6][15:0];
                        mac_d     <= fwd[7][15:0];
                        mac_busy  <= 1'b1;
                        mac_state <= MAC_ACC;
                    end
                end
                MAC_ACC: begin
                    acc       <= acc + {1'b0, prod_cd};
                    mac_state <= MAC_OUT;
                end
                default: begin
                    mac_out   <= acc;
                    mac_done  <= 1'b1;
                    mac_busy  <= 1'b0;
                    mac_state <= MAC_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbapd.sv
// tb_sbapd: directed testbench for sbapd; frames are sent over the serial
// port, then ALU/MAC results and register contents are compared against
// hand-computed values.
module tb_sbapd;

    logic        spi_en, spi_clk, aluop_st, macop_st, rst, clk;
    logic [23:0] spi_wdata;
    logic [15:0] alu_out;
    logic        alu_done, mac_busy, mac_done;
    logic [32:0] mac_out;

    int tests_run    = 0;
    int tests_failed = 0;
    int alu_done_cnt = 0;
    int mac_done_cnt = 0;
    int mac_busy_cnt = 0;

    sbapd #(.SYNC_STAGES(2)) dut (
        .spi_en    (spi_en),
        .spi_clk   (spi_clk),
        .spi_wdata (spi_wdata),
        .aluop_st  (aluop_st),
        .macop_st  (macop_st),
        .rst       (rst),
        .clk       (clk),
        .alu_out   (alu_out),
        .alu_done  (alu_done),
        .mac_out   (mac_out),
        .mac_busy  (mac_busy),
        .mac_done  (mac_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_done) alu_done_cnt++;
        if (mac_done) mac_done_cnt++;
        if (mac_busy) mac_busy_cnt++;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic spi_clks(input int n);
        for (int i = 0; i < n; i++) begin
            spi_clk = 1'b1;
            tick(5);
            spi_clk = 1'b0;
            tick(5);
        end
    endtask

    task automatic spi_frame(input logic [23:0] w, input int nbits, input bit close);
        spi_wdata = w;
        spi_en    = 1'b0;
        tick(6);
        spi_clks(nbits);
        if (close) begin
            tick(6);
            spi_en = 1'b1;
            tick(8);
        end
    endtask

    task automatic pulse_alu();
        aluop_st = 1'b1;
        tick(3);
        aluop_st = 1'b0;
        tick(8);
    endtask

    logic [2:0]  op_tab  [7] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [15:0] res_tab [7] = '{16'h41F4, 16'h81F8, 16'hBFFC, 16'h3E04, 16'h5407, 16'h8000, 16'h000A};

    initial begin
        int a0, m0, b0;
        rst = 1'b0; spi_en = 1'b1; spi_clk = 1'b0; spi_wdata = '0;
        aluop_st = 1'b0; macop_st = 1'b0;
        tick(3);
        check_val("rst_alu_out", 64'(alu_out), 64'h0);
        check_val("rst_alu_done", 64'(alu_done), 64'h0);
        check_val("rst_mac_out", 64'(mac_out), 64'h0);
        check_val("rst_mac_busy", 64'(mac_busy), 64'h0);
        check_val("rst_mac_done", 64'(mac_done), 64'h0);
        rst = 1'b1;
        tick(5);

        spi_frame(24'h010009, 24, 1);
        spi_frame(24'h09ABF8, 24, 1);
        check_val("r0_write", 64'(dut.regs[0]), 64'h10009);
        check_val("r1_write", 64'(dut.regs[1]), 64'h1ABF8);

        spi_frame(24'h1095FC, 24, 1);
        check_val("r2_write", 64'(dut.regs[2]), 64'h095FC);
        a0 = alu_done_cnt;
        pulse_alu();
        check_val("alu_sub", 64'(alu_out), 64'h15FC);
        check_val("alu_sub_done", 64'(alu_done_cnt - a0), 64'd1);

        for (int i = 0; i < 7; i++) begin
            spi_frame({5'b0, op_tab[i], 16'h0000}, 24, 1);
            a0 = alu_done_cnt;
            pulse_alu();
            check_val($sformatf("alu_op%0d", op_tab[i]), 64'(alu_out), 64'(res_tab[i]));
            check_val($sformatf("alu_op%0d_done", op_tab[i]), 64'(alu_done_cnt - a0), 64'd1);
        end

        spi_frame(24'h25ABF8, 24, 1);
        spi_frame(24'h2DEBF8, 24, 1);
        spi_frame(24'h33EBF8, 24, 1);
        spi_frame(24'h39A3F8, 24, 1);
        check_val("r7_write", 64'(dut.regs[7]), 64'h1A3F8);
        m0 = mac_done_cnt; b0 = mac_busy_cnt;
        macop_st = 1'b1;
        tick(3);
        macop_st = 1'b0;
        tick(10);
        check_val("mac_out", 64'(mac_out), 64'h1_35A6_C080);
        check_val("mac_busy_cycles", 64'(mac_busy_cnt - b0), 64'd2);
        check_val("mac_done_pulses", 64'(mac_done_cnt - m0), 64'd1);

        // both starts together, held high to show no retrigger
        spi_frame(24'h000000, 24, 1);
        spi_frame(24'h380001, 24, 1);
        a0 = alu_done_cnt; m0 = mac_done_cnt;
        aluop_st = 1'b1;
        macop_st = 1'b1;
        tick(30);
        aluop_st = 1'b0;
        macop_st = 1'b0;
        tick(8);
        check_val("both_alu_out", 64'(alu_out), 64'h41F4);
        check_val("both_mac_out", 64'(mac_out), 64'h9E84_2C38);
        check_val("both_alu_done", 64'(alu_done_cnt - a0), 64'd1);
        check_val("both_mac_done", 64'(mac_done_cnt - m0), 64'd1);

        // second rising edge lands while the MAC is still busy
        m0 = mac_done_cnt;
        macop_st = 1'b1; tick(1);
        macop_st = 1'b0; tick(1);
        macop_st = 1'b1; tick(1);
        macop_st = 1'b0; tick(10);
        check_val("mac_busy_ignore", 64'(mac_done_cnt - m0), 64'd1);

        spi_frame(24'h181234, 10, 0);
        tick(4);
        spi_en = 1'b1;
        tick(8);
        check_val("abort_r3", 64'(dut.regs[3]), 64'h0);
        check_val("abort_r1", 64'(dut.regs[1]), 64'h1ABF8);
        spi_frame(24'h181234, 24, 1);
        check_val("after_abort_r3", 64'(dut.regs[3]), 64'h01234);
        spi_frame(24'h18ABCD, 28, 1);
        check_val("extra_edges_r3", 64'(dut.regs[3]), 64'h0ABCD);

        // reset in the middle of a frame and a MAC
        spi_frame(24'h201111, 10, 0);
        macop_st = 1'b1;
        tick(3);
        check_val("pre_rst_busy", 64'(mac_busy), 64'h1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_alu_out", 64'(alu_out), 64'h0);
        check_val("mid_rst_mac_out", 64'(mac_out), 64'h0);
        check_val("mid_rst_mac_busy", 64'(mac_busy), 64'h0);
        check_val("mid_rst_r1", 64'(dut.regs[1]), 64'h0);
        check_val("mid_rst_r3", 64'(dut.regs[3]), 64'h0);
        macop_st = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(3);
        spi_clks(24);
        tick(6);
        check_val("no_resume_r4", 64'(dut.regs[4]), 64'h0);
        check_val("post_rst_mac_done", 64'(mac_done), 64'h0);
        spi_en = 1'b1;
        tick(8);
        spi_frame(24'h181234, 24, 1);
        check_val("post_rst_r3", 64'(dut.regs[3]), 64'h01234);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sbapd.md
SBAPD -- requirements
Module: sbapd

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on spi_clk and spi_en (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port spi_en, input, 1 bit: active-low frame enable.
REQ-005 SHALL have port spi_clk, input, 1 bit: serial bit clock, asynchronous to clk, period at least 8 clk periods.
REQ-006 SHALL have port spi_wdata, input, 24 bits: master word, held stable while spi_en is low; bit 23 is sent first.
REQ-007 SHALL have port aluop_st, input, 1 bit: level ALU start; its rising edge triggers one operation.
REQ-008 SHALL have port macop_st, input, 1 bit: level MAC start; its rising edge triggers one operation.
REQ-009 SHALL have port alu_out, output, 16 bits: ALU result.
REQ-010 SHALL have port alu_done, output, 1 bit: one-cycle pulse when alu_out updates.
REQ-011 SHALL have port mac_out, output, 33 bits: MAC result.
REQ-012 SHALL have port mac_busy, output, 1 bit: high while a MAC operation is in progress.
REQ-013 SHALL have port mac_done, output, 1 bit: one-cycle pulse when mac_out updates.
REQ-014 SHALL use positional port order spi_en, spi_clk, spi_wdata, aluop_st, macop_st, rst, clk, alu_out, alu_done, mac_out, mac_busy, mac_done.

Function
REQ-015 SHALL synchronize spi_clk and spi_en into clk through SYNC_STAGES flops, then edge-detect both signals.
REQ-016 SHALL, on a synchronized falling edge of spi_en, clear the bit counter (0..24) and the 24-bit shift register.
REQ-017 SHALL, on each synchronized rising edge of spi_clk while spi_en is low and the counter is below 24:
- shift in spi_wdata[23-count];
- increment the counter.
REQ-018 SHALL, in the clk cycle after the counter reaches 24, write the shift register into the register file:
- address = bits [21:19];
- stored value = bits [18:0];
- bits [23:22] are ignored.
REQ-019 SHALL ignore further spi_clk edges in a frame after 24 bits and perform exactly one write per frame.
REQ-020 SHALL abort the frame with no write if spi_en rises before 24 bits are received.
REQ-021 SHALL implement the register file as R0..R7, each 19 bits; field ctrl = [18:16], field data = [15:0].
REQ-022 SHALL perform one ALU operation one clk after a synchronized rising edge of aluop_st, using opcode R0.ctrl, A = R1.data and B = R2.data:
- 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A;
- 110 SHL A by B[3:0], 111 SHR A by B[3:0];
- result truncated to 16 bits;
- alu_done pulses in the same cycle alu_out updates.
REQ-023 SHALL perform one MAC operation on a rising edge of macop_st:
- cycle 1: acc = R4.data*R5.data (unsigned);
- cycle 2: acc = acc + R6.data*R7.data;
- cycle 3: mac_out = acc (33 bits, no overflow loss) and mac_done pulses;
- mac_busy is high during cycles 1-2.
REQ-024 SHALL ignore a macop_st rising edge while mac_busy is high; holding either start input high SHALL NOT retrigger an operation.
REQ-025 SHALL run the ALU and MAC independently, so simultaneous start edges both complete.
REQ-026 SHALL sample operands at the start cycle; a register write committing in that same cycle SHALL be visible to the operation (write-before-read).

Reset
REQ-027 SHALL, while rst is low, asynchronously clear:
- R0..R7, shift register, bit counter, accumulator and synchronizers;
- alu_out = 0, mac_out = 0, alu_done = 0, mac_busy = 0, mac_done = 0.
REQ-028 SHALL discard any frame or MAC operation in progress when reset asserts; after release, a new spi_en falling edge is required to start a frame.

Verification
REQ-029 SHALL pass: frames 0x010009 and 0x09ABF8 -> R0 = 0x10009 (ctrl 001), R1 = 0x1ABF8.
REQ-030 SHALL pass: frames 0x1095FC (R2) then aluop_st rise -> alu_out = 0x15FC (SUB) with one alu_done pulse.
REQ-031 SHALL pass: R4..R7 written 0x5ABF8, 0x5EBF8, 0x3EBF8, 0x1A3F8, then macop_st rise -> mac_busy high 2 cycles, then mac_out = 0x1_35A6_C080 with one mac_done pulse.
REQ-032 SHALL pass: aluop_st and macop_st raised in the same cycle -> both results produced, each done pulsing once.
REQ-033 SHALL pass: spi_en raised after 10 spi_clk edges -> no register changes; the next full frame writes normally.
REQ-034 SHALL pass: rst pulsed low mid-frame and mid-MAC -> all outputs 0 and registers cleared immediately.
